// File: rtl/iq_split_if.sv
`default_nettype none
// ============================================================================
// Module   : iq_split_if
// Purpose  : Byte-stream input and I/Q sample FIFO write ports of iq_split.
// Revision : 1.0 - initial release
// ============================================================================
interface iq_split_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] I_din;
    logic                  I_wr_en;
    logic                  I_full;
    logic [DATA_WIDTH-1:0] Q_din;
    logic                  Q_wr_en;
    logic                  Q_full;

    // master: the deinterleaver side; slave: the surrounding FIFOs
    modport master (
        input  in_dout, in_empty, I_full, Q_full,
        output in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
    );

    modport slave (
        output in_dout, in_empty, I_full, Q_full,
        input  in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
    );
endinterface
`default_nettype wire

// File: rtl/iq_split.sv
`default_nettype none
// ============================================================================
// Module   : iq_split
// Purpose  : Deinterleaves little-endian IQ byte pairs into quantized I and Q
//            samples and writes them to the I/Q FIFOs in lockstep.
//            Optional macro IQ_SPLIT_SAMPLE_CNT_EN adds a sample_count port.
// Revision : 1.0 - initial release
// ============================================================================
module iq_split #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int QUANT_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
`ifdef IQ_SPLIT_SAMPLE_CNT_EN
    output logic [31:0] sample_count,
`endif
    iq_split_if.master  bus
);

    localparam int c_SAMPLE_W = 2 * BYTE_WIDTH;

    localparam logic [0:0] S_READ  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [0:0]            r_state;
    logic [1:0]            r_idx;
    logic [c_SAMPLE_W-1:0] r_i_raw;
    logic [c_SAMPLE_W-1:0] r_q_raw;

    logic                  w_pop;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_i_ext;
    logic [DATA_WIDTH-1:0] w_q_ext;

    // Reset gates the pop so nothing is consumed while the block is held.
    assign w_pop = (r_state == S_READ) && !bus.in_empty && !reset;
    assign w_wr  = (r_state == S_WRITE) && !bus.I_full && !bus.Q_full;

    assign bus.in_rd_en = w_pop;
    assign bus.I_wr_en  = w_wr;
    assign bus.Q_wr_en  = w_wr;

    // Outputs are pure rewiring of the assembly registers, so they are
    // registered and frozen from the 4th byte capture through S_WRITE.
    assign w_i_ext   = {{(DATA_WIDTH-c_SAMPLE_W){r_i_raw[c_SAMPLE_W-1]}}, r_i_raw};
    assign w_q_ext   = {{(DATA_WIDTH-c_SAMPLE_W){r_q_raw[c_SAMPLE_W-1]}}, r_q_raw};
    assign bus.I_din = w_i_ext << QUANT_BITS;
    assign bus.Q_din = w_q_ext << QUANT_BITS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_READ;
            r_idx   <= 2'd0;
            r_i_raw <= '0;
            r_q_raw <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (w_pop) begin
                        case (r_idx)
                            2'd0:    r_i_raw[BYTE_WIDTH-1:0]          <= bus.in_dout;
                            2'd1:    r_i_raw[c_SAMPLE_W-1:BYTE_WIDTH] <= bus.in_dout;
                            2'd2:    r_q_raw[BYTE_WIDTH-1:0]          <= bus.in_dout;
                            default: r_q_raw[c_SAMPLE_W-1:BYTE_WIDTH] <= bus.in_dout;
                        endcase
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_wr) begin
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_READ;
            endcase
        end
    end

`ifdef IQ_SPLIT_SAMPLE_CNT_EN
    logic [31:0] r_sample_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sample_count <= 32'd0;
        end else if (w_wr) begin
            r_sample_count <= r_sample_count + 32'd1;
        end
    end

    assign sample_count = r_sample_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_split
// Purpose  : Self-checking bench for iq_split with emulated upstream/output FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_split;

    localparam int c_DW = 32;
    localparam int c_BW = 8;
    localparam int c_QB = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iq_split_if #(.DATA_WIDTH(c_DW), .BYTE_WIDTH(c_BW)) bus ();

`ifdef IQ_SPLIT_SAMPLE_CNT_EN
    logic [31:0] sample_count;
`endif

    iq_split #(.DATA_WIDTH(c_DW), .BYTE_WIDTH(c_BW), .QUANT_BITS(c_QB)) dut (
        .clock        (clk),
        .reset        (rst),
`ifdef IQ_SPLIT_SAMPLE_CNT_EN
        .sample_count (sample_count),
`endif
        .bus          (bus)
    );

    // Upstream byte FIFO model (first-word fall-through)
    logic [7:0] byte_mem [0:8191];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic starve = 1'b0;

    assign bus.in_dout  = byte_mem[rd_ptr[12:0]];
    assign bus.in_empty = starve || (rd_ptr == wr_ptr);

    // Output FIFO model and cycle bookkeeping
    int          cyc = 0;
    int          pop_cnt = 0;
    int          last_pop_cyc = -1;
    logic [31:0] i_got[$];
    logic [31:0] q_got[$];
    int          i_wcyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_rd_en) begin
            rd_ptr       <= rd_ptr + 1;
            pop_cnt      <= pop_cnt + 1;
            last_pop_cyc <= cyc;
        end
        if (bus.I_wr_en) begin
            i_got.push_back(bus.I_din);
            i_wcyc.push_back(cyc);
        end
        if (bus.Q_wr_en) q_got.push_back(bus.Q_din);
    end

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] quant(input logic [7:0] lo, input logic [7:0] hi);
        int s;
        s = int'($signed({hi, lo}));
        return 32'(s * (1 << c_QB));
    endfunction

    task automatic push_byte(input logic [7:0] b);
        byte_mem[wr_ptr[12:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_writes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (i_got.size() >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (i_got.size() >= target) ok = 1'b1;
    endtask

    task automatic wait_pops(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (pop_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (pop_cnt >= target) ok = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        push_byte(8'h5A);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en: got %b want 0", bus.in_rd_en);
        end
        checks++;
        if ({bus.I_wr_en, bus.Q_wr_en} !== 2'b00) begin
            errors++;
            $display("FAIL reset_wr_en: got %b want 00", {bus.I_wr_en, bus.Q_wr_en});
        end
        checks++;
        if (bus.I_din !== 32'd0) begin
            errors++;
            $display("FAIL reset_I_din: got %h want 00000000", bus.I_din);
        end
        checks++;
        if (bus.Q_din !== 32'd0) begin
            errors++;
            $display("FAIL reset_Q_din: got %h want 00000000", bus.Q_din);
        end
`ifdef IQ_SPLIT_SAMPLE_CNT_EN
        checks++;
        if (sample_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_sample_count: got %0d want 0", sample_count);
        end
`endif
        wr_ptr = rd_ptr;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pair(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [31:0] want_i, input logic [31:0] want_q);
        int base;
        bit ok;
        base = i_got.size();
        push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3);
        wait_writes(base + 1, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got %0d writes want %0d", name, i_got.size(), base + 1);
            return;
        end
        checks++;
        if (i_got[base] !== want_i) begin
            errors++;
            $display("FAIL %s_I: got %h want %h", name, i_got[base], want_i);
        end
        checks++;
        if (q_got.size() != i_got.size() || q_got[base] !== want_q) begin
            errors++;
            $display("FAIL %s_Q: got %h (count %0d) want %h", name, q_got[base], q_got.size(), want_q);
        end
        checks++;
        if (i_wcyc[base] - last_pop_cyc != 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 1", name, i_wcyc[base] - last_pop_cyc);
        end
    endtask

    task automatic test_starvation;
        int  base, p0, w0;
        bit  ok;
        logic [31:0] want_i, want_q;
        base = i_got.size();
        p0   = pop_cnt;
        push_byte(8'h78); push_byte(8'h56);
        wait_pops(p0 + 2, 20, ok);
        starve = 1'b1;
        push_byte(8'h21); push_byte(8'h43);
        w0 = i_got.size();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_rd_en, bus.I_wr_en} !== 2'b00) begin
                errors++;
                $display("FAIL starve_gap: got rd/wr %b want 00", {bus.in_rd_en, bus.I_wr_en});
            end
        end
        checks++;
        if (pop_cnt != p0 + 2 || i_got.size() != w0) begin
            errors++;
            $display("FAIL starve_counts: got pops %0d writes %0d want %0d %0d",
                     pop_cnt - p0, i_got.size() - w0, 2, 0);
        end
        starve = 1'b0;
        wait_writes(base + 1, 50, ok);
        want_i = quant(8'h78, 8'h56);
        want_q = quant(8'h21, 8'h43);
        checks++;
        if (!ok || i_got[base] !== want_i || q_got[base] !== want_q) begin
            errors++;
            $display("FAIL starve_data: got %h/%h want %h/%h", i_got[base], q_got[base], want_i, want_q);
        end
    endtask

    task automatic test_backpressure;
        int  base, p0;
        bit  ok;
        logic [7:0] a [4];
        logic [7:0] b [4];
        base = i_got.size();
        p0   = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            a[k] = 8'($urandom);
            b[k] = 8'($urandom);
        end
        bus.Q_full = 1'b1;
        for (int k = 0; k < 4; k++) push_byte(a[k]);
        for (int k = 0; k < 4; k++) push_byte(b[k]);
        wait_pops(p0 + 4, 20, ok);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({bus.in_rd_en, bus.I_wr_en, bus.Q_wr_en} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold: got rd/I/Q %b want 000",
                         {bus.in_rd_en, bus.I_wr_en, bus.Q_wr_en});
            end
            @(negedge clk);
        end
        checks++;
        if (i_got.size() != base || q_got.size() != base || pop_cnt != p0 + 4) begin
            errors++;
            $display("FAIL bp_counts: got I %0d Q %0d pops %0d want %0d %0d %0d",
                     i_got.size(), q_got.size(), pop_cnt - p0, base, base, 4);
        end
        bus.Q_full = 1'b0;
        wait_writes(base + 2, 60, ok);
        checks++;
        if (!ok || q_got.size() != i_got.size()) begin
            errors++;
            $display("FAIL bp_release: got I %0d Q %0d want %0d each", i_got.size(), q_got.size(), base + 2);
        end else begin
            checks++;
            if (i_got[base] !== quant(a[0], a[1]) || q_got[base] !== quant(a[2], a[3])) begin
                errors++;
                $display("FAIL bp_pair0: got %h/%h want %h/%h", i_got[base], q_got[base],
                         quant(a[0], a[1]), quant(a[2], a[3]));
            end
            checks++;
            if (i_got[base+1] !== quant(b[0], b[1]) || q_got[base+1] !== quant(b[2], b[3])) begin
                errors++;
                $display("FAIL bp_pair1: got %h/%h want %h/%h", i_got[base+1], q_got[base+1],
                         quant(b[0], b[1]), quant(b[2], b[3]));
            end
        end
    endtask

    task automatic test_reset_mid;
        int base, p0;
        bit ok;
        p0 = pop_cnt;
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        wait_pops(p0 + 3, 20, ok);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = i_got.size();
        push_byte(8'h01); push_byte(8'h00); push_byte(8'h02); push_byte(8'h00);
        wait_writes(base + 1, 50, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || i_got.size() != base + 1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d writes want 1", i_got.size() - base);
        end else begin
            checks++;
            if (i_got[base] !== 32'h0000_0400 || q_got[base] !== 32'h0000_0800) begin
                errors++;
                $display("FAIL rstmid_data: got %h/%h want 00000400/00000800", i_got[base], q_got[base]);
            end
        end
    endtask

    task automatic test_streaming;
        int base;
        int done;
        logic [31:0] exp_i[$];
        logic [31:0] exp_q[$];
        logic [7:0]  bb [4];
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = i_got.size();
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 4; k++) begin
                bb[k] = 8'($urandom);
                push_byte(bb[k]);
            end
            exp_i.push_back(quant(bb[0], bb[1]));
            exp_q.push_back(quant(bb[2], bb[3]));
        end
        done = 0;
        for (int c = 0; c < 40000; c++) begin
            if (i_got.size() >= base + 1000) begin
                done = 1;
                break;
            end
            starve     = ($urandom_range(0, 3) == 0);
            bus.I_full = ($urandom_range(0, 4) == 0);
            bus.Q_full = ($urandom_range(0, 4) == 0);
            @(negedge clk);
        end
        starve     = 1'b0;
        bus.I_full = 1'b0;
        bus.Q_full = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done == 0 || i_got.size() != base + 1000 || q_got.size() != i_got.size()) begin
            errors++;
            $display("FAIL stream_count: got I %0d Q %0d want %0d", i_got.size() - base,
                     q_got.size() - base, 1000);
        end else begin
            for (int n = 0; n < 1000; n++) begin
                checks++;
                if (i_got[base+n] !== exp_i[n] || q_got[base+n] !== exp_q[n]) begin
                    errors++;
                    $display("FAIL stream_pair%0d: got %h/%h want %h/%h", n,
                             i_got[base+n], q_got[base+n], exp_i[n], exp_q[n]);
                end
            end
        end
`ifdef IQ_SPLIT_SAMPLE_CNT_EN
        checks++;
        if (sample_count !== 32'd1000) begin
            errors++;
            $display("FAIL stream_sample_count: got %0d want 1000", sample_count);
        end
`endif
    endtask

    initial begin
        rst        = 1'b1;
        bus.I_full = 1'b0;
        bus.Q_full = 1'b0;
        @(negedge clk);
        test_reset();
        test_pair("basic", 8'h34, 8'h12, 8'hCD, 8'hAB, 32'h0048_D000, 32'hFEAF_3400);
        test_pair("extremes", 8'hFF, 8'h7F, 8'h00, 8'h80, 32'h01FF_FC00, 32'hFE00_0000);
        test_starvation();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
